// File: rtl/fixed_div_if.sv
// Handshake and operand/result bundle for the sequential fixed-point divider.
// The master side launches operations and the slave side is the divider.
interface fixed_div_if #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int QW = 24
);
  logic          start;
  logic          round;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [QW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          busy;
  logic          ack;

  modport master (
    output start, round, dividend, divisor,
    input  quotient, remainder, div_zero, busy, ack
  );

  modport slave (
    input  start, round, dividend, divisor,
    output quotient, remainder, div_zero, busy, ack
  );
endinterface

// File: rtl/fixed_div_unit.sv
// Sequential restoring divider: quotient = floor(dividend * 2^(QW-DW) / divisor),
// optional half-LSB rounding with saturation, fixed latency of QW+1 cycles.
module fixed_div_unit #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int QW = 24
) (
  input logic        clk,
  input logic        rst_n,
  fixed_div_if.slave bus
);
  localparam int FB = QW - DW;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, RUN, RND, DONE} state_t;

  state_t        state;
  logic [QW-1:0] num_q;   // numerator bits shift out the top, quotient bits shift in
  logic [VW-1:0] rem_q;
  logic [VW-1:0] dvs_q;
  logic          rnd_q;
  logic [CW-1:0] cnt_q;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          ge;
  logic [VW-1:0] rem_nxt;

  function automatic logic [QW-1:0] round_sat(input logic [QW-1:0] q,
                                              input logic [VW-1:0] r,
                                              input logic [VW-1:0] d,
                                              input logic          en);
    logic [VW:0] twice;
    twice = {r, 1'b0};
    if (en && (twice >= {1'b0, d}) && (q != '1))
      return q + QW'(1);
    return q;
  endfunction

  assign trial   = {rem_q, num_q[QW-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign ge      = (trial >= {1'b0, dvs_q});
  assign rem_nxt = ge ? diff[VW-1:0] : trial[VW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      rnd_q         <= 1'b0;
      cnt_q         <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.ack       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            num_q    <= QW'(bus.dividend) << FB;
            rem_q    <= '0;
            dvs_q    <= bus.divisor;
            rnd_q    <= bus.round;
            cnt_q    <= CW'(QW);
            bus.ack  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        // One restoring step per cycle, MSB of the numerator first
        RUN: begin
          num_q <= {num_q[QW-2:0], ge};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state <= RND;
        end
        RND: begin
          if (dvs_q == '0) begin
            bus.quotient  <= '1;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b1;
          end else begin
            bus.quotient  <= round_sat(num_q, rem_q, dvs_q, rnd_q);
            bus.remainder <= rem_q;
            bus.div_zero  <= 1'b0;
          end
          bus.ack  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_div_unit.sv
// Directed bench for fixed_div_unit: default 16/8->24 build plus an 8/1->8 build.
module tb_fixed_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  fixed_div_if #(.DW(16), .VW(8), .QW(24)) bus ();
  fixed_div_if #(.DW(8),  .VW(1), .QW(8))  sbus ();

  fixed_div_unit #(.DW(16), .VW(8), .QW(24)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fixed_div_unit #(.DW(8), .VW(1), .QW(8)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; drives operands, lets the next edge (E0) accept them.
  task automatic launch(input logic [15:0] dvd, input logic [7:0] dvs, input logic rnd);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.round    = rnd;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    chk("busy_after_e0", 32'(bus.busy), 32'd1);
    chk("ack_after_e0",  32'(bus.ack),  32'd0);
  endtask

  // Counts edges after E0 until ack; optionally pulses start with 100/7 at cycle inj.
  task automatic wait_ack(output int n, input int inj);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == inj) begin
        bus.dividend = 16'd100;
        bus.divisor  = 8'd7;
        bus.round    = 1'b1;
        bus.start    = 1'b1;
      end else if (n == inj + 1) begin
        bus.start    = 1'b0;
      end
      if (bus.ack) break;
    end
    if (!bus.ack) chk("ack_timeout", 32'(bus.ack), 32'd1);
  endtask

  initial begin
    bus.start = 1'b0; bus.round = 1'b0; bus.dividend = '0; bus.divisor = '0;
    sbus.start = 1'b0; sbus.round = 1'b0; sbus.dividend = '0; sbus.divisor = '0;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_quotient", 32'(bus.quotient),  32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero),  32'd0);
    chk("rst_busy",     32'(bus.busy),      32'd0);
    chk("rst_ack",      32'(bus.ack),       32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    launch(16'd385, 8'd6, 1'b0);
    wait_ack(lat, 0);
    chk("trunc_latency", 32'(lat), 32'd25);
    chk("trunc_q",  32'(bus.quotient),  32'h00402A);
    chk("trunc_r",  32'(bus.remainder), 32'd4);
    chk("trunc_dz", 32'(bus.div_zero),  32'd0);
    chk("trunc_busy_done", 32'(bus.busy), 32'd0);

    launch(16'd385, 8'd6, 1'b1);
    wait_ack(lat, 0);
    chk("round_q", 32'(bus.quotient),  32'h00402B);
    chk("round_r", 32'(bus.remainder), 32'd4);

    launch(16'd3, 8'd255, 1'b0);
    wait_ack(lat, 0);
    chk("small_q", 32'(bus.quotient),  32'h000003);
    chk("small_r", 32'(bus.remainder), 32'd3);

    launch(16'd65535, 8'd1, 1'b1);
    wait_ack(lat, 0);
    chk("max_q", 32'(bus.quotient),  32'hFFFF00);
    chk("max_r", 32'(bus.remainder), 32'd0);

    launch(16'd1234, 8'd0, 1'b1);
    wait_ack(lat, 0);
    chk("dz_latency", 32'(lat), 32'd25);
    chk("dz_q",  32'(bus.quotient),  32'hFFFFFF);
    chk("dz_r",  32'(bus.remainder), 32'd0);
    chk("dz_dz", 32'(bus.div_zero),  32'd1);

    // Start pulsed while busy must be ignored; old result holds during the run
    launch(16'd385, 8'd6, 1'b0);
    chk("hold_q_run", 32'(bus.quotient), 32'hFFFFFF);
    wait_ack(lat, 10);
    chk("busy_start_latency", 32'(lat), 32'd25);
    chk("busy_start_q",  32'(bus.quotient),  32'h00402A);
    chk("busy_start_r",  32'(bus.remainder), 32'd4);
    chk("busy_start_dz", 32'(bus.div_zero),  32'd0);

    launch(16'd100, 8'd7, 1'b0);
    wait_ack(lat, 0);
    chk("from_done_latency", 32'(lat), 32'd25);
    chk("from_done_q", 32'(bus.quotient),  32'h000E49);
    chk("from_done_r", 32'(bus.remainder), 32'd1);

    launch(16'd385, 8'd6, 1'b0);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_quotient",  32'(bus.quotient),  32'd0);
    chk("mid_rst_remainder", 32'(bus.remainder), 32'd0);
    chk("mid_rst_busy",      32'(bus.busy),      32'd0);
    chk("mid_rst_ack",       32'(bus.ack),       32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", 32'(bus.ack), 32'd0);
    launch(16'd385, 8'd6, 1'b0);
    wait_ack(lat, 0);
    chk("post_rst_latency", 32'(lat), 32'd25);
    chk("post_rst_q", 32'(bus.quotient), 32'h00402A);

    // Narrow build: QW = DW = 8, VW = 1, full-scale result must not wrap
    sbus.dividend = 8'd255;
    sbus.divisor  = 1'b1;
    sbus.round    = 1'b1;
    sbus.start    = 1'b1;
    @(posedge clk); #1;
    sbus.start    = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (sbus.ack) break;
    end
    chk("sat_ack",     32'(sbus.ack),       32'd1);
    chk("sat_latency", 32'(lat),            32'd9);
    chk("sat_q",       32'(sbus.quotient),  32'hFF);
    chk("sat_r",       32'(sbus.remainder), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
